// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and parameter legality checks for the FIFO family.
package fifo_pkg;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic bit params_ok(input int depth, input int af, input int ae);
    return depth >= 2 && (depth & (depth - 1)) == 0 &&
           af >= 1 && af <= depth && ae >= 0 && ae <= depth - 1;
  endfunction
endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer handshake and status bundle of the FIFO.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH = 8
);
  logic wrt_en, rd_en, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [DATA_W-1:0] data_in, data_out;
  logic [cnt_w(DEPTH)-1:0] count;
  modport master(
    output wrt_en, data_in, rd_en,
    input data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave(
    input wrt_en, data_in, rd_en,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: DEPTH x DATA_W storage, synchronous write, asynchronous read, no reset.
module fifo_mem_2p #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised show-ahead single-clock FIFO with occupancy,
// threshold flags and registered overflow/underflow pulses.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input logic clk,
  input logic rst_n,
  sync_fifo_param_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  if (!params_ok(DEPTH, AF_THRESH, AE_THRESH) || DATA_W < 1) begin : g_bad_params
    $error("sync_fifo_param: illegal DATA_W/DEPTH/threshold parameters");
  end
  logic [CW-1:0] wr_ptr, rd_ptr, cnt;
  logic [DATA_W-1:0] rd_data;
  logic full_s, empty_s, wr_acc, rd_acc, ovf_q, udf_q;
  always_comb begin
    empty_s = wr_ptr == rd_ptr;
    full_s = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    wr_acc = bus.wrt_en && !full_s;
    rd_acc = bus.rd_en && !empty_s;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + CW'(wr_acc);
      rd_ptr <= rd_ptr + CW'(rd_acc);
      cnt <= cnt + CW'(wr_acc) - CW'(rd_acc);
      ovf_q <= bus.wrt_en && full_s;
      udf_q <= bus.rd_en && empty_s;
    end
  fifo_mem_2p #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(wr_acc),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(bus.data_in),
    .raddr(rd_ptr[ADDR_W-1:0]),
    .rdata(rd_data)
  );
  // empty masks the read port so unwritten storage never reaches data_out
  assign bus.data_out = empty_s ? '0 : rd_data;
  assign bus.full = full_s;
  assign bus.empty = empty_s;
  assign bus.almost_full = cnt >= CW'(AF_THRESH);
  assign bus.almost_empty = cnt <= CW'(AE_THRESH);
  assign bus.count = cnt;
  assign bus.overflow = ovf_q;
  assign bus.underflow = udf_q;
  a_flags_match_count: assert property (@(posedge clk) disable iff (!rst_n)
    (empty_s == (cnt == '0)) && (full_s == (cnt == CW'(DEPTH))));
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, the next generation of the team's 16-bit x 8 synchronous FIFO. It is generic in data width and depth and allows a read and a write in the same cycle. It adds an occupancy count, programmable almost-full/almost-empty flags, and registered overflow/underflow error pulses. It sits between producer and consumer blocks in the same clock domain and keeps the existing show-ahead read behaviour.

## Interface
- DATA_W, 16: data word width in bits, >= 1
- DEPTH, 8: number of entries; power of two, >= 2
- ADDR_W, $clog2(DEPTH): derived, not overridden
- AF_THRESH, DEPTH-2: almost_full asserts when count >= AF_THRESH; range 1..DEPTH
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH; range 0..DEPTH-1

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wrt_en  in  1  write request
- data_in  in  DATA_W  write data
- rd_en  in  1  read request (pops the current head)
- data_out  out  DATA_W  head entry (show-ahead)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: a write was rejected
- underflow  out  1  one-cycle pulse: a read was rejected

## Operation
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W+1 bits wide; the MSB is the wrap bit, and the low ADDR_W bits index the storage.
  - Both increment modulo 2^(ADDR_W+1).
- Accepted write: wr_acc = wrt_en & ~full.
  - Stores data_in at wr_ptr[ADDR_W-1:0].
  - wr_ptr increments.
- Accepted read: rd_acc = rd_en & ~empty. rd_ptr increments.
- Writes and reads are independent. Both may be accepted in one cycle.
- count register:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
- Flag derivation:
  - empty = (wr_ptr == rd_ptr).
  - full = wrap bits differ and low bits equal.
  - full and empty must always agree with count; this is an assertion invariant.
- Full, with wrt_en & rd_en together: the read is accepted and the write is rejected (overflow pulses). The FIFO is then DEPTH-1 full.
- Empty, with wrt_en & rd_en together: the write is accepted and the read is rejected (underflow pulses). No write-through bypass.
- overflow is registered: it is 1 in the cycle after an edge where wrt_en & full, otherwise 0.
- underflow is registered: it is 1 in the cycle after an edge where rd_en & empty, otherwise 0.
- data_out:
  - Equals storage[rd_ptr[ADDR_W-1:0]] when ~empty.
  - Forced to all-zeros when empty, so the output never shows stale or uninitialised storage.
- Storage is not reset. Contents are only observable through data_out while non-empty.

## Timing
- Reset (async assert, release synchronised by the system):
  - wr_ptr = rd_ptr = 0, count = 0.
  - empty = 1, full = 0, almost_empty = 1.
  - almost_full = 0, overflow = 0, underflow = 0, data_out = 0.
- Reset asserted mid-operation:
  - All the above take effect immediately, without a clock edge.
  - Buffered data is discarded.
- Write latency:
  - A word written at edge N is on data_out in the cycle after edge N, if the FIFO was empty.
  - empty falls after the same edge N.
- Read latency:
  - With rd_en high at edge N, data_out shows the next entry after edge N, or zeros if the FIFO is now empty.
- Flag timing:
  - All status outputs depend only on registered state.
  - They update after the edge and never combinationally on wrt_en or rd_en.
- Wrap-around: after 2^(ADDR_W+1) writes, wr_ptr returns to 0 with no effect on correctness.

## Structure
- Shared package fifo_pkg holds:
  - A function for counter width (ADDR_W+1).
  - Localparam checks: DEPTH power of two; AF/AE threshold ranges. Elaboration fails on violation.
- One sub-module, fifo_mem_2p: a DEPTH x DATA_W array with synchronous write port and asynchronous read port.
- Pointer, count, flag and error logic stay in the top module.

## Test plan
- Reset, then idle for 5 cycles -> empty=1, almost_empty=1, count=0, data_out=0; all other flags 0.
- DATA_W=16, DEPTH=8: write 0x0001..0x0008 on consecutive cycles ->
  - full=1 and count=8 after the 8th edge.
  - almost_full first asserts after the 6th write.
  - A 9th write pulses overflow for one cycle with count still 8.
  - Reading all 8 returns 0x0001..0x0008 in order, and empty=1 after the 8th read.
- Full FIFO, wrt_en=rd_en=1 for one cycle -> count=7, overflow=1; the head advances to the second entry.
- Empty FIFO, wrt_en=rd_en=1 with data_in=0xBEEF -> count=1, underflow=1 next cycle, data_out=0xBEEF.
- Half-full FIFO (4 entries), 20 cycles of simultaneous read+write with an incrementing pattern ->
  - count stays 4 throughout.
  - Output order is preserved.
  - Pointers cross the wrap boundary at least once.
- Write 5 entries, assert rst_n=0 between clock edges -> all outputs reach their reset values before the next edge; a subsequent single write/read round-trips correctly.
